sha256_block_fetch_pad: RTL and testbench

Upstream feeder for the SHA-256 compression core. On start, it reads a NUM_OF_WORDS-word raw message from word-addressed synchronous memory and appends standard SHA-256 padding. It then delivers the result one 512-bit block at a time to the core over a valid/ready handshake. This replaces in-core READ/padding logic, so the core sees only complete padded blocks.

---
 rtl/sha256_pkg.sv | 20 ++
 rtl/sha256_pad_word.sv | 29 ++
 rtl/sha256_block_fetch_pad.sv | 153 +++++++++++++++
 tb/tb_sha256_block_fetch_pad.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and helpers used by the block feeder and the compression core.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } state_t;

  typedef logic [511:0] block_t;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  // Number of 512-bit blocks needed for an n-word message after padding:
  // n words + 1 pad word + 2 length words, rounded up to a multiple of 16.
  function automatic int num_blocks(input int n);
    return (n + 2) / 16 + 1;
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Classifies one word of the padded stream: message word (fetched from memory)
// or a constant pad word (0x80000000 marker, zero fill, or the bit length).
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [15:0] g,
  input  logic [15:0] n,
  input  logic        is_last,
  input  logic [3:0]  slot,
  output logic        is_mem,
  output logic [31:0] pad_value
);

  logic [31:0] bit_len;

  // Length in bits; the upper 32 bits of the 64-bit length field are always zero.
  assign bit_len = {11'd0, n, 5'd0};
  assign is_mem  = (g < n);

  // Pad constant for a non-message word; slot 14 of the last block falls into zero fill.
  always_comb begin
    pad_value = 32'd0;
    if (g == n)
      pad_value = PAD_WORD;
    else if (is_last && slot == 4'd15)
      pad_value = bit_len;
  end

endmodule

// File: rtl/sha256_block_fetch_pad.sv
// Reads a raw message from synchronous word memory, pads it SHA-256 style and
// hands it to the compression core one complete 512-bit block at a time.
module sha256_block_fetch_pad
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  input_addr,
  input  logic [31:0]  memory_read_data,
  output logic         memory_clk,
  output logic [15:0]  memory_addr,
  output logic         blk_valid,
  input  logic         blk_ready,
  output block_t       blk_data,
  output logic [7:0]   blk_index,
  output logic         blk_last,
  output logic         busy,
  output logic         done
);

  localparam int          NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
  localparam logic [15:0] N_W        = 16'(NUM_OF_WORDS);
  localparam logic [7:0]  LAST_IDX   = 8'(NUM_BLOCKS - 1);

  state_t             state;
  logic [4:0]         cyc;
  logic [15:0]        base;
  logic [15:0][31:0]  word_buf;

  // Address side: which slot gets its address on the coming edge
  logic [7:0]         fa_blk;
  logic [3:0]         fa_slot;
  logic [15:0]        fa_base;
  logic [15:0]        fa_g;
  logic               fa_go;
  logic               fa_mem;

  // Write side: slot whose data arrives this cycle (one cycle behind its address)
  logic [3:0]         wr_slot_p1;
  logic [15:0]        wr_g_p1;
  logic               wr_is_mem_p1;
  logic [31:0]        wr_pad_p1;
  logic               wr_vld_p1;

  assign memory_clk = clk;
  assign blk_data   = word_buf;

  assign wr_slot_p1 = 4'(cyc - 5'd1);
  assign wr_g_p1    = {4'd0, blk_index, wr_slot_p1};
  assign wr_vld_p1  = (state == FETCH) && (cyc != 5'd0);

  sha256_pad_word u_pad (
    .g         (wr_g_p1),
    .n         (N_W),
    .is_last   (blk_index == LAST_IDX),
    .slot      (wr_slot_p1),
    .is_mem    (wr_is_mem_p1),
    .pad_value (wr_pad_p1)
  );

  // Pick the stream word whose read address is issued on the next edge, if it is a message word.
  always_comb begin
    fa_blk  = blk_index;
    fa_slot = 4'd0;
    fa_base = base;
    fa_go   = 1'b0;
    case (state)
      IDLE: begin
        fa_blk  = 8'd0;
        fa_base = input_addr;
        fa_go   = start;
      end
      FETCH: begin
        fa_slot = 4'(cyc + 5'd1);
        fa_go   = (cyc < 5'd15);
      end
      PRESENT: begin
        fa_blk = blk_index + 8'd1;
        fa_go  = blk_valid && blk_ready && !blk_last;
      end
      default: ;
    endcase
    fa_g   = {4'd0, fa_blk, fa_slot};
    fa_mem = fa_go && (fa_g < N_W);
  end

  // Control FSM: 17-cycle fetch per block, then hold the block until the core takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cyc         <= 5'd0;
      base        <= 16'd0;
      blk_index   <= 8'd0;
      blk_valid   <= 1'b0;
      blk_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      memory_addr <= 16'd0;
    end else begin
      done <= 1'b0;
      if (fa_mem)
        memory_addr <= fa_base + fa_g;
      case (state)
        IDLE: begin
          if (start) begin
            base      <= input_addr;
            blk_index <= 8'd0;
            cyc       <= 5'd0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (cyc == 5'd16) begin
            blk_valid <= 1'b1;
            blk_last  <= (blk_index == LAST_IDX);
            state     <= PRESENT;
          end else begin
            cyc <= cyc + 5'd1;
          end
        end
        PRESENT: begin
          if (blk_valid && blk_ready) begin
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            if (blk_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              blk_index <= blk_index + 8'd1;
              cyc       <= 5'd0;
              state     <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Block buffer: capture memory data or a pad constant one cycle after the slot's address cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_buf <= '0;
    else if (wr_vld_p1)
      word_buf[4'd15 - wr_slot_p1] <= wr_is_mem_p1 ? memory_read_data : wr_pad_p1;
  end

endmodule

// File: tb/tb_sha256_block_fetch_pad.sv
// Randomized bench for sha256_block_fetch_pad: four instances (N = 40, 13, 14, 16)
// against a padding reference model built with the plain SHA-256 padding rule.
module tb_sha256_block_fetch_pad;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_v       [4];
  logic [15:0]  input_addr_v  [4];
  logic [31:0]  rdata_v       [4];
  logic         memory_clk_v  [4];
  logic [15:0]  memory_addr_v [4];
  logic         blk_valid_v   [4];
  logic         blk_ready_v   [4];
  logic [511:0] blk_data_v    [4];
  logic [7:0]   blk_index_v   [4];
  logic         blk_last_v    [4];
  logic         busy_v        [4];
  logic         done_v        [4];

  logic [31:0]  mem [65536];
  logic [31:0]  exp_w [$];
  logic [15:0]  exp_addr [4];
  int           checks = 0;
  int           errors = 0;
  int           n_of   [4] = '{40, 13, 14, 16};

  sha256_block_fetch_pad #(.NUM_OF_WORDS(40)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .input_addr(input_addr_v[0]),
    .memory_read_data(rdata_v[0]), .memory_clk(memory_clk_v[0]), .memory_addr(memory_addr_v[0]),
    .blk_valid(blk_valid_v[0]), .blk_ready(blk_ready_v[0]), .blk_data(blk_data_v[0]),
    .blk_index(blk_index_v[0]), .blk_last(blk_last_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  sha256_block_fetch_pad #(.NUM_OF_WORDS(13)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .input_addr(input_addr_v[1]),
    .memory_read_data(rdata_v[1]), .memory_clk(memory_clk_v[1]), .memory_addr(memory_addr_v[1]),
    .blk_valid(blk_valid_v[1]), .blk_ready(blk_ready_v[1]), .blk_data(blk_data_v[1]),
    .blk_index(blk_index_v[1]), .blk_last(blk_last_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  sha256_block_fetch_pad #(.NUM_OF_WORDS(14)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .input_addr(input_addr_v[2]),
    .memory_read_data(rdata_v[2]), .memory_clk(memory_clk_v[2]), .memory_addr(memory_addr_v[2]),
    .blk_valid(blk_valid_v[2]), .blk_ready(blk_ready_v[2]), .blk_data(blk_data_v[2]),
    .blk_index(blk_index_v[2]), .blk_last(blk_last_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  sha256_block_fetch_pad #(.NUM_OF_WORDS(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .input_addr(input_addr_v[3]),
    .memory_read_data(rdata_v[3]), .memory_clk(memory_clk_v[3]), .memory_addr(memory_addr_v[3]),
    .blk_valid(blk_valid_v[3]), .blk_ready(blk_ready_v[3]), .blk_data(blk_data_v[3]),
    .blk_index(blk_index_v[3]), .blk_last(blk_last_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // Synchronous memories: data appears one cycle after the address.
  always @(posedge clk)
    for (int i = 0; i < 4; i++) rdata_v[i] <= mem[memory_addr_v[i]];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference padded stream: message, 0x80000000, zero fill to 14 mod 16, 64-bit bit length.
  task automatic build_stream(input int n, input logic [15:0] base);
    exp_w.delete();
    for (int k = 0; k < n; k++) exp_w.push_back(mem[base + 16'(k)]);
    exp_w.push_back(32'h8000_0000);
    while (exp_w.size() % 16 != 14) exp_w.push_back(32'h0);
    exp_w.push_back(32'h0);
    exp_w.push_back(32'(n * 32));
  endtask

  // One complete message on instance i with per-block checks.
  task automatic run_msg(input int i, input logic [15:0] base, input int stall_blk,
                         input int stall_len, input bit noise);
    int n, nb, c, stall;
    logic [511:0] exp_blk;
    n = n_of[i];
    build_stream(n, base);
    nb = exp_w.size() / 16;
    if (noise) begin
      blk_ready_v[i] = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        checks++;
        if (blk_valid_v[i] !== 1'b0 || busy_v[i] !== 1'b0) begin
          errors++;
          $display("FAIL idle_ready inst%0d: valid=%b busy=%b, want 0 0", i, blk_valid_v[i], busy_v[i]);
        end
      end
      blk_ready_v[i] = 1'b0;
    end
    input_addr_v[i] = base;
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    input_addr_v[i] = 16'($urandom);
    checks++;
    if (busy_v[i] !== 1'b1) begin
      errors++;
      $display("FAIL busy_on_start inst%0d: got %b want 1", i, busy_v[i]);
    end
    for (int b = 0; b < nb; b++) begin
      c = 0;
      while (blk_valid_v[i] !== 1'b1 && c < 40) begin
        if (c < 16 && (16 * b + c) < n) exp_addr[i] = base + 16'(16 * b + c);
        if (c <= 16) begin
          checks++;
          if (memory_addr_v[i] !== exp_addr[i]) begin
            errors++;
            $display("FAIL fetch_addr inst%0d blk%0d cyc%0d: got %h want %h", i, b, c, memory_addr_v[i], exp_addr[i]);
          end
        end
        if (noise) begin
          start_v[i] = 1'($urandom_range(0, 1));
          blk_ready_v[i] = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        c++;
      end
      start_v[i] = 1'b0;
      blk_ready_v[i] = 1'b0;
      checks++;
      if (c !== 17) begin
        errors++;
        $display("FAIL latency inst%0d blk%0d: got %0d edges want 17", i, b, c);
      end
      if (blk_valid_v[i] !== 1'b1) return;
      for (int s = 0; s < 16; s++) exp_blk[511 - 32 * s -: 32] = exp_w[16 * b + s];
      checks++;
      if (blk_data_v[i] !== exp_blk) begin
        errors++;
        $display("FAIL blk_data inst%0d blk%0d: got %h want %h", i, b, blk_data_v[i], exp_blk);
      end
      checks++;
      if (blk_index_v[i] !== 8'(b) || blk_last_v[i] !== (b == nb - 1)) begin
        errors++;
        $display("FAIL index_last inst%0d blk%0d: got idx %0d last %b want idx %0d last %b",
                 i, b, blk_index_v[i], blk_last_v[i], b, (b == nb - 1));
      end
      checks++;
      if (busy_v[i] !== 1'b1 || done_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL busy_done_present inst%0d blk%0d: got busy %b done %b want 1 0", i, b, busy_v[i], done_v[i]);
      end
      stall = (b == stall_blk) ? stall_len : int'($urandom_range(0, 2));
      for (int s = 0; s < stall; s++) begin
        if (noise) start_v[i] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        checks++;
        if (blk_valid_v[i] !== 1'b1 || blk_data_v[i] !== exp_blk || blk_index_v[i] !== 8'(b)) begin
          errors++;
          $display("FAIL hold inst%0d blk%0d: got valid %b idx %0d data %h want 1 %0d %h",
                   i, b, blk_valid_v[i], blk_index_v[i], blk_data_v[i], b, exp_blk);
        end
        checks++;
        if (memory_addr_v[i] !== exp_addr[i]) begin
          errors++;
          $display("FAIL stall_addr inst%0d blk%0d: got %h want %h", i, b, memory_addr_v[i], exp_addr[i]);
        end
      end
      blk_ready_v[i] = 1'b1;
      start_v[i] = (noise && b != nb - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      blk_ready_v[i] = 1'b0;
      start_v[i] = 1'b0;
      checks++;
      if (blk_valid_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL valid_drop inst%0d blk%0d: got %b want 0", i, b, blk_valid_v[i]);
      end
      if (b == nb - 1) begin
        checks++;
        if (done_v[i] !== 1'b1 || busy_v[i] !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse inst%0d: got done %b busy %b want 1 0", i, done_v[i], busy_v[i]);
        end
        @(posedge clk); #1;
        checks++;
        if (done_v[i] !== 1'b0) begin
          errors++;
          $display("FAIL done_width inst%0d: got %b want 0", i, done_v[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      blk_ready_v[i] = 1'b0;
      input_addr_v[i] = 16'h0;
      exp_addr[i] = 16'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (blk_valid_v[i] !== 1'b0 || blk_data_v[i] !== 512'd0 || blk_index_v[i] !== 8'd0 ||
          blk_last_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || memory_addr_v[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_values inst%0d: valid %b idx %0d last %b busy %b done %b addr %h data %h, want all zero",
                 i, blk_valid_v[i], blk_index_v[i], blk_last_v[i], busy_v[i], done_v[i], memory_addr_v[i], blk_data_v[i]);
      end
      checks++;
      if (memory_clk_v[i] !== clk) begin
        errors++;
        $display("FAIL memory_clk inst%0d: got %b want %b", i, memory_clk_v[i], clk);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_plan_n40();
    for (int k = 0; k < 40; k++) mem[16'h0100 + k] = 32'(k + 1);
    run_msg(0, 16'h0100, -1, 0, 1'b0);
  endtask

  task automatic test_boundaries();
    run_msg(1, 16'($urandom), -1, 0, 1'b0);
    run_msg(2, 16'($urandom), -1, 0, 1'b0);
    run_msg(3, 16'($urandom), -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_msg(0, 16'($urandom), 1, 10, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    run_msg(2, 16'($urandom), -1, 0, 1'b1);
    run_msg(0, 16'($urandom), -1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_and_wrap();
    int c;
    input_addr_v[0] = 16'($urandom);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    c = 0;
    while (blk_valid_v[0] !== 1'b1 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    blk_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    blk_ready_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (blk_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || memory_addr_v[0] !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_fetch: valid %b busy %b done %b addr %h want 0 0 0 0",
               blk_valid_v[0], busy_v[0], done_v[0], memory_addr_v[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_addr[i] = 16'h0;
    // Reset while a block is presented: valid must fall without a clock edge.
    input_addr_v[0] = 16'($urandom);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    c = 0;
    while (blk_valid_v[0] !== 1'b1 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (blk_valid_v[0] !== 1'b0 || blk_data_v[0] !== 512'd0 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_present: valid %b busy %b data %h want 0 0 0", blk_valid_v[0], busy_v[0], blk_data_v[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_addr[i] = 16'h0;
    @(posedge clk); #1;
    run_msg(0, 16'hFFF8, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      run_msg(1, 16'($urandom), -1, 0, 1'b0);
      run_msg(3, 16'($urandom), -1, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_plan_n40();
    test_boundaries();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid_and_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
